hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Consumes the EX-stage register addresses from the ID/EX segment register plus MEM/WB destinations and produces every stage's `bubble`/`flush` pair and the EX operand forwarding selects. It also runs a small state machine that freezes the pipeline during data-cache misses, with saturating performance counters and a miss-timeout error flag.

## Interface
- `MISS_TIMEOUT`, 1024: maximum WAIT cycles before `miss_err` sets.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg1_src_D`, `reg2_src_D`  in  5 each  source register addresses of the instruction in ID.
- `reg1_src_EX`, `reg2_src_EX`, `reg_dest_EX`  in  5 each  source and destination register addresses in EX.
- `load_EX`  in  1  the instruction in EX is a load.
- `reg_dest_MEM`  in  5  destination register in MEM.
- `reg_write_MEM`  in  1  the instruction in MEM writes a register.
- `reg_dest_WB`  in  5  destination register in WB.
- `reg_write_WB`  in  1  the instruction in WB writes a register.
- `br_taken_EX`, `jalr_EX`  in  1 each  taken branch / jalr resolved in EX.
- `jal_ID`  in  1  jal decoded in ID.
- `dcache_miss`  in  1  the data-cache access in MEM missed this cycle.
- `dcache_ready`  in  1  the refill is complete and the data is valid.
- `bubbleF/D/E/M/W`, `flushF/D/E/M/W`  out  1 each  per-stage hold and clear controls; bubble has priority over flush in the segment registers.
- `op1_sel`, `op2_sel`  out  2 each  forwarding select: 00 = register file, 01 = MEM result, 10 = WB result.
- `miss_stall_cnt`, `load_use_cnt`  out  `CNT_W` each  saturating event counters.
- `miss_err`  out  1  sticky miss-timeout flag.

## Operation
- **FSM states:** IDLE and WAIT.
  - IDLE → WAIT when `dcache_miss && !dcache_ready`.
  - WAIT → IDLE when `dcache_ready`.
  - `dcache_miss && dcache_ready` in the same cycle while in IDLE causes no stall.
- **In WAIT:**
  - All five bubbles are 1 and all flushes are 0.
  - Load-use and control hazard outputs are suppressed; they are re-evaluated naturally after release because the stage contents are frozen.
- **In IDLE, priority order (highest first):**
  1. `br_taken_EX || jalr_EX`: `flushD=1`, `flushE=1`. All bubbles are 0.
  2. Load-use, defined as `load_EX && reg_dest_EX!=0 && (reg_dest_EX==reg1_src_D || reg_dest_EX==reg2_src_D)`: `bubbleF=1`, `bubbleD=1`, `flushE=1`.
  3. `jal_ID`: `flushD=1`.
  4. Otherwise all controls are 0.
- **Forwarding:** combinational and active in every state. For each of `reg1_src_EX` and `reg2_src_EX`:
  - select 01 if `reg_write_MEM && reg_dest_MEM!=0 && match`;
  - else select 10 if `reg_write_WB && reg_dest_WB!=0 && match`;
  - else select 00.
  - MEM beats WB. Register x0 is never forwarded.
- **Counters:**
  - `load_use_cnt` increments on each cycle in which priority item 2 is active.
  - `miss_stall_cnt` increments on each cycle spent in WAIT.
  - Both saturate at 2^`CNT_W`−1 and never wrap.
- **Timeout:**
  - A WAIT-cycle counter of width clog2(`MISS_TIMEOUT`)+1 is cleared on entry to WAIT.
  - When it reaches `MISS_TIMEOUT`, `miss_err` is set and stays 1 until reset.
  - The FSM remains in WAIT until `dcache_ready` regardless of timeout.

## Timing
- **Reset values:** state IDLE, all counters 0, `miss_err` 0.
- **While `rst_n` is low:**
  - `flushF/D/E/M/W` = 1 and all bubbles = 0, so the pipeline clears.
  - `op1_sel` and `op2_sel` = 00.
- **Control outputs:** combinational from the current state and current inputs; no added latency. A load-use hazard holds ID for exactly one cycle; the next cycle the load is in MEM and forwarding via 01 resolves the dependency.
- **Stall onset:** the cycle that `dcache_miss` is asserted in IDLE is itself already stalled, because bubbles are driven combinationally from `dcache_miss && !dcache_ready`.
- **Stall release:** the cycle `dcache_ready` is seen in WAIT, bubbles are 0 and the pipeline advances on that edge.
- **Reset mid-WAIT:** the FSM returns to IDLE immediately and the counters clear.

## Test plan
- Load-use: EX holds lw x5 with `load_EX=1`, `reg_dest_EX=5`, `reg1_src_D=5` → for one cycle `bubbleF=bubbleD=flushE=1`, `load_use_cnt` 0→1; next cycle `op1_sel=01`.
- Forward priority: `reg1_src_EX=7`, MEM and WB both write x7 → `op1_sel=01`. Repeat with `reg1_src_EX=0` → `op1_sel=00`.
- Branch overrides load-use: `br_taken_EX=1` with a load-use condition also present → `flushD=flushE=1`, `bubbleF=0`, `load_use_cnt` unchanged.
- Cache miss: `dcache_miss=1` for 4 cycles, then `dcache_ready=1` → all bubbles=1 for 4 cycles, release on the 5th, `miss_stall_cnt`=4. Same-cycle miss+ready → no stall.
- Timeout: `MISS_TIMEOUT=8`, hold a miss for 12 cycles → `miss_err` rises after 8 WAIT cycles and stays 1 after release; asserting `rst_n=0` mid-WAIT clears it to 0 and returns the FSM to IDLE.
- Counter saturation: `CNT_W=4`, 20 load-use cycles → `load_use_cnt` holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Generates per-stage bubble/flush controls and EX operand forwarding selects.
// Freezes the pipeline during data-cache misses.
// Keeps saturating event counters and a sticky miss-timeout flag.
module hazard_ctrl #(
   parameter int unsigned MISS_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       reg1_src_D,
   input  logic [4:0]       reg2_src_D,
   input  logic [4:0]       reg1_src_EX,
   input  logic [4:0]       reg2_src_EX,
   input  logic [4:0]       reg_dest_EX,
   input  logic             load_EX,
   input  logic [4:0]       reg_dest_MEM,
   input  logic             reg_write_MEM,
   input  logic [4:0]       reg_dest_WB,
   input  logic             reg_write_WB,
   input  logic             br_taken_EX,
   input  logic             jalr_EX,
   input  logic             jal_ID,
   input  logic             dcache_miss,
   input  logic             dcache_ready,
   output logic             bubbleF,
   output logic             bubbleD,
   output logic             bubbleE,
   output logic             bubbleM,
   output logic             bubbleW,
   output logic             flushF,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic [1:0]       op1_sel,
   output logic [1:0]       op2_sel,
   output logic [CNT_W-1:0] miss_stall_cnt,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic             miss_err
);

   localparam int unsigned TW = $clog2(MISS_TIMEOUT) + 1;
   localparam logic [TW-1:0] TimeoutVal = TW'(MISS_TIMEOUT);
   localparam logic [TW-1:0] TimeoutM1  = TW'(MISS_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e        state_q;
   logic [TW-1:0] wait_cnt_q;

   logic stall;
   logic ctrl_haz;
   logic load_use;
   logic lu_active;

   // Forwarding select for one EX source operand; MEM beats WB, x0 never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] dest_mem, input logic wr_mem,
                                          input logic [4:0] dest_wb,  input logic wr_wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_mem && (dest_mem != 5'd0) && (dest_mem == src)) begin
         sel = 2'b01;
      end else if (wr_wb && (dest_wb != 5'd0) && (dest_wb == src)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   // Hazard detection; the miss-onset cycle stalls before the FSM reaches WAIT.
   always_comb begin
      if (state_q == StWait) begin
         stall = !dcache_ready;
      end else begin
         stall = dcache_miss && !dcache_ready;
      end
      ctrl_haz  = br_taken_EX || jalr_EX;
      load_use  = load_EX && (reg_dest_EX != 5'd0) &&
                  ((reg_dest_EX == reg1_src_D) || (reg_dest_EX == reg2_src_D));
      lu_active = !stall && !ctrl_haz && load_use;
   end

   // Per-stage bubble/flush controls, highest priority first.
   always_comb begin
      {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b00000;
      {flushF, flushD, flushE, flushM, flushW}      = 5'b00000;
      if (!rst_n) begin
         {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
      end else if (stall) begin
         {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
      end else if (ctrl_haz) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (load_use) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         flushE  = 1'b1;
      end else if (jal_ID) begin
         flushD = 1'b1;
      end
   end

   // Operand forwarding, active in every state; forced to register file during reset.
   always_comb begin
      op1_sel = 2'b00;
      op2_sel = 2'b00;
      if (rst_n) begin
         op1_sel = fwd_sel(reg1_src_EX, reg_dest_MEM, reg_write_MEM, reg_dest_WB, reg_write_WB);
         op2_sel = fwd_sel(reg2_src_EX, reg_dest_MEM, reg_write_MEM, reg_dest_WB, reg_write_WB);
      end
   end

   // Miss FSM with timeout tracking and saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         wait_cnt_q     <= '0;
         miss_err       <= 1'b0;
         miss_stall_cnt <= '0;
         load_use_cnt   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (dcache_miss && !dcache_ready) begin
                  state_q    <= StWait;
                  wait_cnt_q <= '0;
               end
            end
            StWait: begin
               if (wait_cnt_q != TimeoutVal) begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
               // Flag is set on the edge that completes the MISS_TIMEOUT-th WAIT cycle.
               if (wait_cnt_q >= TimeoutM1) begin
                  miss_err <= 1'b1;
               end
               if (dcache_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
         if ((state_q == StWait) && (miss_stall_cnt != '1)) begin
            miss_stall_cnt <= miss_stall_cnt + 1'b1;
         end
         if (lu_active && (load_use_cnt != '1)) begin
            load_use_cnt <= load_use_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs, monitor compares.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] reg1_src_D, reg2_src_D, reg1_src_EX, reg2_src_EX, reg_dest_EX;
   logic       load_EX;
   logic [4:0] reg_dest_MEM, reg_dest_WB;
   logic       reg_write_MEM, reg_write_WB;
   logic       br_taken_EX, jalr_EX, jal_ID, dcache_miss, dcache_ready;
   logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
   logic       flushF, flushD, flushE, flushM, flushW;
   logic [1:0] op1_sel, op2_sel;
   logic [3:0] miss_stall_cnt, load_use_cnt;
   logic       miss_err;

   hazard_ctrl #(
      .MISS_TIMEOUT(8),
      .CNT_W       (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .reg1_src_D    (reg1_src_D),
      .reg2_src_D    (reg2_src_D),
      .reg1_src_EX   (reg1_src_EX),
      .reg2_src_EX   (reg2_src_EX),
      .reg_dest_EX   (reg_dest_EX),
      .load_EX       (load_EX),
      .reg_dest_MEM  (reg_dest_MEM),
      .reg_write_MEM (reg_write_MEM),
      .reg_dest_WB   (reg_dest_WB),
      .reg_write_WB  (reg_write_WB),
      .br_taken_EX   (br_taken_EX),
      .jalr_EX       (jalr_EX),
      .jal_ID        (jal_ID),
      .dcache_miss   (dcache_miss),
      .dcache_ready  (dcache_ready),
      .bubbleF       (bubbleF),
      .bubbleD       (bubbleD),
      .bubbleE       (bubbleE),
      .bubbleM       (bubbleM),
      .bubbleW       (bubbleW),
      .flushF        (flushF),
      .flushD        (flushD),
      .flushE        (flushE),
      .flushM        (flushM),
      .flushW        (flushW),
      .op1_sel       (op1_sel),
      .op2_sel       (op2_sel),
      .miss_stall_cnt(miss_stall_cnt),
      .load_use_cnt  (load_use_cnt),
      .miss_err      (miss_err)
   );

   typedef struct packed {
      logic [4:0] b;    // {F,D,E,M,W}
      logic [4:0] f;    // {F,D,E,M,W}
      logic [1:0] o1;
      logic [1:0] o2;
      logic [3:0] lu;
      logic [3:0] ms;
      logic       err;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    vectors;
   int    miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      reg1_src_D    = '0;
      reg2_src_D    = '0;
      reg1_src_EX   = '0;
      reg2_src_EX   = '0;
      reg_dest_EX   = '0;
      load_EX       = 1'b0;
      reg_dest_MEM  = '0;
      reg_write_MEM = 1'b0;
      reg_dest_WB   = '0;
      reg_write_WB  = 1'b0;
      br_taken_EX   = 1'b0;
      jalr_EX       = 1'b0;
      jal_ID        = 1'b0;
      dcache_miss   = 1'b0;
      dcache_ready  = 1'b0;
   endtask

   // Queue the expected response for the current inputs, then advance one cycle.
   task automatic step(input string nm, input logic [4:0] b, input logic [4:0] f,
                       input logic [1:0] o1, input logic [1:0] o2,
                       input logic [3:0] lu, input logic [3:0] ms, input logic err);
      exp_t e;
      e.b   = b;
      e.f   = f;
      e.o1  = o1;
      e.o2  = o2;
      e.lu  = lu;
      e.ms  = ms;
      e.err = err;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step("reset", 5'b00000, 5'b11111, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      rst_n = 1'b1;
      clear_inputs();
   endtask

   // Monitor: outputs are sampled on the falling edge, mid-cycle.
   initial begin : monitor
      exp_t  e;
      exp_t  a;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            nm    = name_q.pop_front();
            a.b   = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW};
            a.f   = {flushF, flushD, flushE, flushM, flushW};
            a.o1  = op1_sel;
            a.o2  = op2_sel;
            a.lu  = load_use_cnt;
            a.ms  = miss_stall_cnt;
            a.err = miss_err;
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL %s: got b=%b f=%b op1=%b op2=%b lu=%0d ms=%0d err=%b, want b=%b f=%b op1=%b op2=%b lu=%0d ms=%0d err=%b",
                        nm, a.b, a.f, a.o1, a.o2, a.lu, a.ms, a.err,
                        e.b, e.f, e.o1, e.o2, e.lu, e.ms, e.err);
            end
         end
      end
   end

   initial begin : driver
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;

      // Reset: flushes high, forwarding forced off despite matching MEM write.
      reg1_src_EX   = 5'd7;
      reg_dest_MEM  = 5'd7;
      reg_write_MEM = 1'b1;
      br_taken_EX   = 1'b1;
      dcache_miss   = 1'b1;
      step("reset_hold", 5'b00000, 5'b11111, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      rst_n = 1'b1;
      clear_inputs();
      step("idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);

      // Load-use then MEM forwarding of the load result.
      load_EX = 1'b1; reg_dest_EX = 5'd5; reg1_src_D = 5'd5;
      step("load_use", 5'b11000, 5'b00100, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      clear_inputs();
      reg_dest_MEM = 5'd5; reg_write_MEM = 1'b1; reg1_src_EX = 5'd5;
      step("lu_fwd_mem", 5'b00000, 5'b00000, 2'b01, 2'b00, 4'd1, 4'd0, 1'b0);
      clear_inputs();
      load_EX = 1'b1; reg_dest_EX = 5'd0;
      step("lu_x0", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
      clear_inputs();
      load_EX = 1'b1; reg_dest_EX = 5'd9; reg1_src_D = 5'd3; reg2_src_D = 5'd9;
      step("lu_rs2", 5'b11000, 5'b00100, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
      reg2_src_D = 5'd4;
      step("lu_nomatch", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);

      // Forwarding priority.
      clear_inputs();
      reg1_src_EX = 5'd7; reg2_src_EX = 5'd7;
      reg_dest_MEM = 5'd7; reg_write_MEM = 1'b1; reg_dest_WB = 5'd7; reg_write_WB = 1'b1;
      step("fwd_mem_wins", 5'b00000, 5'b00000, 2'b01, 2'b01, 4'd2, 4'd0, 1'b0);
      reg_write_MEM = 1'b0;
      step("fwd_wb", 5'b00000, 5'b00000, 2'b10, 2'b10, 4'd2, 4'd0, 1'b0);
      reg_write_MEM = 1'b1; reg_dest_MEM = 5'd6; reg2_src_EX = 5'd6;
      step("fwd_split", 5'b00000, 5'b00000, 2'b10, 2'b01, 4'd2, 4'd0, 1'b0);
      reg1_src_EX = 5'd0; reg2_src_EX = 5'd0; reg_dest_MEM = 5'd0; reg_dest_WB = 5'd0;
      step("fwd_x0", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);
      reg1_src_EX = 5'd7; reg_dest_MEM = 5'd7; reg_dest_WB = 5'd7;
      reg_write_MEM = 1'b0; reg_write_WB = 1'b0;
      step("fwd_nowrite", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);

      // Control hazards versus load-use.
      clear_inputs();
      load_EX = 1'b1; reg_dest_EX = 5'd5; reg1_src_D = 5'd5; br_taken_EX = 1'b1;
      step("br_over_lu", 5'b00000, 5'b01100, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);
      br_taken_EX = 1'b0; jalr_EX = 1'b1;
      step("jalr_over_lu", 5'b00000, 5'b01100, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);
      jalr_EX = 1'b0; jal_ID = 1'b1;
      step("lu_over_jal", 5'b11000, 5'b00100, 2'b00, 2'b00, 4'd2, 4'd0, 1'b0);
      clear_inputs();
      jal_ID = 1'b1;
      step("jal", 5'b00000, 5'b01000, 2'b00, 2'b00, 4'd3, 4'd0, 1'b0);
      clear_inputs();
      step("idle2", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd3, 4'd0, 1'b0);

      // Cache miss: stall from onset, hazards suppressed, forwarding live, release on ready.
      do_reset();
      dcache_miss = 1'b1;
      step("miss_onset", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      br_taken_EX = 1'b1;
      step("wait_br", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      br_taken_EX = 1'b0; load_EX = 1'b1; reg_dest_EX = 5'd5; reg1_src_D = 5'd5;
      step("wait_lu", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd1, 1'b0);
      clear_inputs();
      dcache_miss = 1'b1; reg1_src_EX = 5'd3; reg_dest_WB = 5'd3; reg_write_WB = 1'b1;
      step("wait_fwd", 5'b11111, 5'b00000, 2'b10, 2'b00, 4'd0, 4'd2, 1'b0);
      clear_inputs();
      dcache_ready = 1'b1;
      step("release", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd3, 1'b0);
      clear_inputs();
      step("after_release", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd4, 1'b0);
      dcache_miss = 1'b1; dcache_ready = 1'b1;
      step("miss_ready_same", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd4, 1'b0);
      clear_inputs();
      step("no_stall", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd4, 1'b0);

      // Timeout after 8 WAIT cycles, sticky across release, cleared by reset mid-WAIT.
      do_reset();
      dcache_miss = 1'b1;
      step("to_onset", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         step($sformatf("to_wait%0d", k), 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0,
              4'(k - 1), (k >= 9));
      end
      dcache_miss = 1'b0; dcache_ready = 1'b1;
      step("to_release", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd11, 1'b1);
      clear_inputs();
      step("to_err_sticky", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd12, 1'b1);
      dcache_miss = 1'b1;
      step("to_miss2", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd12, 1'b1);
      step("to_wait2", 5'b11111, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd12, 1'b1);
      rst_n = 1'b0;
      step("to_rst_mid", 5'b00000, 5'b11111, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
      rst_n = 1'b1;
      clear_inputs();
      step("to_idle_after_rst", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);

      // Load-use counter saturation at 15.
      do_reset();
      load_EX = 1'b1; reg_dest_EX = 5'd5; reg1_src_D = 5'd5;
      for (int k = 1; k <= 20; k++) begin
         step($sformatf("lu_sat%0d", k), 5'b11000, 5'b00100, 2'b00, 2'b00,
              4'((k > 16) ? 15 : (k - 1)), 4'd0, 1'b0);
      end
      clear_inputs();
      step("lu_sat_hold", 5'b00000, 5'b00000, 2'b00, 2'b00, 4'd15, 4'd0, 1'b0);

      // Drain the scoreboard, bounded.
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
